// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared image geometry, fetch FSM states and pixel-beat record
package lenet_pkg;

  localparam int PIX_WD = 16;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int ADDR_W = 10;
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [PIX_WD-1:0] data;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              last;
  } pix_beat_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// rtl/pix_skid_fifo.sv - two-entry pixel-beat FIFO with registered head
module pix_skid_fifo
  import lenet_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  pix_beat_t  din,
  input  logic       pop,
  output pix_beat_t  dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  pix_beat_t  slot0, slot1;
  logic [1:0] cnt;
  logic       do_pop;

  assign do_pop = pop & (cnt != 2'd0);

  // slot0 is always the head, so dout comes straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 1'b1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign count = cnt;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/image_fetch_ctrl.sv
// rtl/image_fetch_ctrl.sv - reads one image from the synchronous ROM and streams it in raster order
module image_fetch_ctrl #(
  parameter int WD    = lenet_pkg::PIX_WD,
  parameter int IMG_W = lenet_pkg::IMG_W,
  parameter int IMG_H = lenet_pkg::IMG_H,
  parameter int AW    = lenet_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     cena_image,
  output logic [AW-1:0]            aa_image,
  input  logic [WD-1:0]            qa_image,
  output logic [WD-1:0]            pix_data,
  output logic [$clog2(IMG_H)-1:0] pix_row,
  output logic [$clog2(IMG_W)-1:0] pix_col,
  output logic                     pix_last,
  output logic                     pix_valid,
  input  logic                     pix_ready
);
  import lenet_pkg::*;

  localparam int N  = IMG_W * IMG_H;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  fetch_state_t    state, state_next;
  logic [AW-1:0]   addr, aa_q;
  logic [RW-1:0]   row, tag_row;
  logic [CW-1:0]   col, tag_col;
  logic            tag_last, inflight;
  logic            issue, pop, last_addr;
  logic [2:0]      credit;
  logic [1:0]      fifo_cnt;
  logic            fifo_full, fifo_empty, fifo_push;
  pix_beat_t       push_beat, head;

  assign pop       = pix_valid & pix_ready;
  assign last_addr = (addr == AW'(N - 1));
  // occupancy after this cycle's pop; a read now lands two cycles later
  assign credit    = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == FETCH) && (credit < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = FETCH;
      FETCH:   if (issue && last_addr) state_next = DRAIN;
      DRAIN:   if (pop && head.last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      aa_q     <= '0;
      row      <= '0;
      col      <= '0;
      tag_row  <= '0;
      tag_col  <= '0;
      tag_last <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && go) begin
        addr <= '0;
        row  <= '0;
        col  <= '0;
      end else if (issue) begin
        aa_q     <= addr;
        tag_row  <= row;
        tag_col  <= col;
        tag_last <= last_addr;
        if (!last_addr) begin
          addr <= addr + 1'b1;
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  assign cena_image = ~issue;
  assign aa_image   = issue ? addr : aa_q;

  assign push_beat = '{data: qa_image, row: tag_row, col: tag_col, last: tag_last};
  assign fifo_push = inflight & (~fifo_full | pop);

  pix_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pix_valid  = ~fifo_empty;
  assign pix_data   = head.data;
  assign pix_row    = head.row;
  assign pix_col    = head.col;
  assign pix_last   = head.last;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
